seg7_clock_sequencer: RTL and testbench

Run/stop controller and digit-scan scheduler for the seven-segment seconds display. Generates the one-second tick from the system clock and maintains an MM:SS BCD count. Accepts start, stop, clear and preset commands from the input pins. Time-multiplexes the single shared 7-segment bus across four common-cathode digits, with inter-digit blanking. Sits between the top-level `ui_in`/`uo_out`/`uio_out` pins and the display.

---
 rtl/seg7_clock_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_seg7_clock_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_clock_sequencer.sv
// rtl/seg7_clock_sequencer.sv - run/stop MM:SS BCD counter with multiplexed seven-segment scan
//
// Purpose:
//   Divides the system clock down to a one-second tick and keeps an MM:SS BCD
//   count. A STOP/RUN control FSM accepts start, stop, clear and preset
//   commands. A scan FSM drives one shared 7-segment bus across four
//   common-cathode digits, with all-off blanking slots between digits.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   ena         in   design selected; low freezes all state and blanks the display
//   cmd_start   in   single-cycle pulse, STOP -> RUN
//   cmd_stop    in   single-cycle pulse, RUN -> STOP
//   cmd_clear   in   single-cycle pulse, count and prescaler to zero
//   load_valid  in   preset request
//   load_value  in   BCD preset {m_tens, m_units, s_tens, s_units}
//   load_ready  out  high while stopped (preset can be accepted)
//   load_err    out  one-cycle pulse when an accepted preset is not valid BCD time
//   seg         out  segments gfedcba, active high, seg[0] = a
//   dp          out  decimal point, only ever lit on digit 2
//   dig_en      out  one-hot digit enable, bit 0 = seconds units
//   running     out  high in RUN
//   sec_tick    out  one-cycle pulse on each count increment

module seg7_clock_sequencer #(
    parameter int TICK_DIV     = 10_000_000,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_clear,
    input  logic        load_valid,
    input  logic [15:0] load_value,
    output logic        load_ready,
    output logic        load_err,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_en,
    output logic        running,
    output logic        sec_tick
);

    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SLOT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int SW       = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

    localparam logic [PW-1:0] LP_TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] LP_TICK_HALF  = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0] LP_SHOW_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] LP_BLANK_LAST = SW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    typedef enum logic {
        SC_SHOW  = 1'b0,
        SC_BLANK = 1'b1
    } scan_state_t;

    // Control state
    run_state_t    r_state;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_count;
    logic          r_running;
    logic          r_load_ready;
    logic          r_sec_tick;
    logic          r_load_err;

    // Scan state
    scan_state_t   r_scan;
    logic [1:0]    r_digit;
    logic [SW-1:0] r_slot;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_dig_en;

    logic          w_load_accept;
    logic          w_load_bcd_ok;
    logic          w_tick;
    logic          w_dp_on;
    logic [3:0]    w_digit_val;

    // MM:SS BCD increment; 59:59 rolls over to 00:00.
    function automatic logic [15:0] f_bcd_inc(input logic [15:0] c);
        logic [15:0] n;
        n = c;
        if (c[3:0] != 4'd9) begin
            n[3:0] = c[3:0] + 4'd1;
        end else begin
            n[3:0] = 4'd0;
            if (c[7:4] != 4'd5) begin
                n[7:4] = c[7:4] + 4'd1;
            end else begin
                n[7:4] = 4'd0;
                if (c[11:8] != 4'd9) begin
                    n[11:8] = c[11:8] + 4'd1;
                end else begin
                    n[11:8] = 4'd0;
                    if (c[15:12] != 4'd5) begin
                        n[15:12] = c[15:12] + 4'd1;
                    end else begin
                        n[15:12] = 4'd0;
                    end
                end
            end
        end
        return n;
    endfunction

    // Common-cathode decode, gfedcba; codes above 9 cannot occur but blank safely.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_load_accept = load_valid && r_load_ready;

    assign w_load_bcd_ok = (load_value[15:12] <= 4'd5) &&
                           (load_value[11:8]  <= 4'd9) &&
                           (load_value[7:4]   <= 4'd5) &&
                           (load_value[3:0]   <= 4'd9);

    assign w_tick = (r_state == ST_RUN) && (r_presc == LP_TICK_LAST);

    // Separator is steady when stopped and blinks with the first half-second when running.
    assign w_dp_on = (r_digit == 2'd2) &&
                     ((r_state == ST_STOP) || (r_presc < LP_TICK_HALF));

    always_comb begin
        w_digit_val = 4'd0;
        case (r_digit)
            2'd0:    w_digit_val = r_count[3:0];
            2'd1:    w_digit_val = r_count[7:4];
            2'd2:    w_digit_val = r_count[11:8];
            default: w_digit_val = r_count[15:12];
        endcase
    end

    // Control FSM, prescaler and count. The if/else chain encodes the
    // command priority clear > load > stop > start > normal counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_STOP;
            r_presc      <= '0;
            r_count      <= 16'h0000;
            r_running    <= 1'b0;
            r_load_ready <= 1'b1;
            r_sec_tick   <= 1'b0;
            r_load_err   <= 1'b0;
        end else if (!ena) begin
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
            if (cmd_clear) begin
                r_count <= 16'h0000;
                r_presc <= '0;
            end else if (w_load_accept) begin
                if (w_load_bcd_ok) begin
                    r_count <= load_value;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (cmd_stop) begin
                // Prescaler deliberately holds across a stop.
                r_state      <= ST_STOP;
                r_running    <= 1'b0;
                r_load_ready <= 1'b1;
            end else if (cmd_start && (r_state == ST_STOP)) begin
                r_state      <= ST_RUN;
                r_running    <= 1'b1;
                r_load_ready <= 1'b0;
                r_presc      <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_tick) begin
                    r_presc    <= '0;
                    r_count    <= f_bcd_inc(r_count);
                    r_sec_tick <= 1'b1;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

    // Scan FSM: SHOW(d) for SCAN_DIV cycles, then BLANK for BLANK_CYCLES,
    // then SHOW(d+1). The blank slot guarantees no two digits are lit in
    // adjacent cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan   <= SC_SHOW;
            r_digit  <= 2'd0;
            r_slot   <= '0;
            r_seg    <= 7'h00;
            r_dp     <= 1'b0;
            r_dig_en <= 4'b0000;
        end else if (!ena) begin
            r_seg    <= 7'h00;
            r_dp     <= 1'b0;
            r_dig_en <= 4'b0000;
        end else begin
            case (r_scan)
                SC_SHOW: begin
                    r_dig_en <= 4'b0001 << r_digit;
                    r_seg    <= f_decode(w_digit_val);
                    r_dp     <= w_dp_on;
                    if (r_slot == LP_SHOW_LAST) begin
                        r_slot <= '0;
                        r_scan <= SC_BLANK;
                    end else begin
                        r_slot <= r_slot + SW'(1);
                    end
                end
                default: begin
                    r_dig_en <= 4'b0000;
                    r_seg    <= 7'h00;
                    r_dp     <= 1'b0;
                    if (r_slot == LP_BLANK_LAST) begin
                        r_slot  <= '0;
                        r_scan  <= SC_SHOW;
                        r_digit <= r_digit + 2'd1;
                    end else begin
                        r_slot <= r_slot + SW'(1);
                    end
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign load_err   = r_load_err;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign dig_en     = r_dig_en;
    assign running    = r_running;
    assign sec_tick   = r_sec_tick;

endmodule

// File: tb/tb_seg7_clock_sequencer.sv
// tb/tb_seg7_clock_sequencer.sv - self-checking bench for seg7_clock_sequencer
`timescale 1ns/1ps
module tb_seg7_clock_sequencer;

    localparam int TICK_DIV     = 10;
    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int SCAN_PERIOD  = 4 * (SCAN_DIV + BLANK_CYCLES);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cmd_start;
    logic        cmd_stop;
    logic        cmd_clear;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic        load_err;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    logic        running;
    logic        sec_tick;

    seg7_clock_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_clear  (cmd_clear),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .load_err   (load_err),
        .seg        (seg),
        .dp         (dp),
        .dig_en     (dig_en),
        .running    (running),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       running;
        logic       tick;
        logic       err;
        logic       ready;
    } outv_t;

    typedef struct {
        logic [15:0] value;
        logic        exp_err;
        logic [15:0] exp_count;
    } load_vec_t;

    outv_t     sb_q[$];
    load_vec_t lv[8];
    int        checks = 0;
    int        errors = 0;
    int        cyc_n  = 0;

    // Reference model: count kept as total seconds, scan as phase/digit/slot.
    int m_run, m_presc, m_secs, m_phase, m_dig, m_slot;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int digit_of(input int secs, input int d);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        case (d)
            0: return ss % 10;
            1: return ss / 10;
            2: return mm % 10;
            default: return mm / 10;
        endcase
    endfunction

    function automatic logic [27:0] exp_digits(input logic [15:0] bcd);
        return {seg_of(int'(bcd[15:12])), seg_of(int'(bcd[11:8])),
                seg_of(int'(bcd[7:4])), seg_of(int'(bcd[3:0]))};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_presc = 0; m_secs = 0; m_phase = 0; m_dig = 0; m_slot = 0;
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        outv_t e;
        int mt, mu, st, su;
        e = '0;
        if (ena) begin
            if (m_phase == 0) begin
                e.dig = 4'b0001 << m_dig;
                e.seg = seg_of(digit_of(m_secs, m_dig));
                e.dp  = (m_dig == 2) && ((m_run == 0) || (m_presc < TICK_DIV / 2));
                if (m_slot == SCAN_DIV - 1) begin m_slot = 0; m_phase = 1; end
                else m_slot++;
            end else begin
                if (m_slot == BLANK_CYCLES - 1) begin m_slot = 0; m_phase = 0; m_dig = (m_dig + 1) % 4; end
                else m_slot++;
            end
            if (cmd_clear) begin
                m_secs = 0; m_presc = 0;
            end else if (load_valid && (m_run == 0)) begin
                mt = int'(load_value[15:12]); mu = int'(load_value[11:8]);
                st = int'(load_value[7:4]);   su = int'(load_value[3:0]);
                if (mt <= 5 && mu <= 9 && st <= 5 && su <= 9) m_secs = (mt * 10 + mu) * 60 + st * 10 + su;
                else e.err = 1'b1;
            end else if (cmd_stop) begin
                m_run = 0;
            end else if (cmd_start && (m_run == 0)) begin
                m_run = 1; m_presc = 0;
            end else if (m_run != 0) begin
                m_presc++;
                if (m_presc == TICK_DIV) begin
                    m_presc = 0; m_secs = (m_secs + 1) % 3600; e.tick = 1'b1;
                end
            end
        end
        e.running = (m_run != 0);
        e.ready   = (m_run == 0);
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        outv_t e, a;
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0; load_valid = 1'b0;
        e = sb_q.pop_front();
        a.seg = seg; a.dp = dp; a.dig = dig_en; a.running = running;
        a.tick = sec_tick; a.err = load_err; a.ready = load_ready;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL sb cycle=%0d actual=%h expected=%h", cyc_n, a, e);
        end
    endtask

    task automatic wait_dig(input logic [3:0] target, input string name);
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * SCAN_PERIOD && !found; i++) begin
            prev = dig_en;
            cyc();
            if (dig_en == target && prev != target) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic wait_tick(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < TICK_DIV + 5 && !found; i++) begin
            cyc();
            if (sec_tick) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic cap_digits(output logic [27:0] cap);
        cap = '0;
        for (int i = 0; i < SCAN_PERIOD; i++) begin
            cyc();
            case (dig_en)
                4'b0001: cap[6:0]   = seg;
                4'b0010: cap[13:7]  = seg;
                4'b0100: cap[20:14] = seg;
                4'b1000: cap[27:21] = seg;
                default: ;
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout cycle=%0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  rec_dig[SCAN_PERIOD];
        logic        rec_dp[SCAN_PERIOD];
        logic [6:0]  rec_seg[SCAN_PERIOD];
        logic [27:0] cap;
        logic [3:0]  e_dig;
        int t1, t2, nt, n;
        bit done;

        lv[0] = '{16'h1234, 1'b0, 16'h1234};
        lv[1] = '{16'h0A00, 1'b1, 16'h1234};
        lv[2] = '{16'h5959, 1'b0, 16'h5959};
        lv[3] = '{16'h6000, 1'b1, 16'h5959};
        lv[4] = '{16'h0060, 1'b1, 16'h5959};
        lv[5] = '{16'h000A, 1'b1, 16'h5959};
        lv[6] = '{16'h0907, 1'b0, 16'h0907};
        lv[7] = '{16'h5958, 1'b0, 16'h5958};

        rst_n = 1'b0; ena = 1'b1;
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
        load_valid = 1'b0; load_value = 16'h0000;
        model_reset();

        // Reset values, then first edge after release
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({seg, dp, dig_en, running, sec_tick, load_err, load_ready}), 32'h0001);
        rst_n = 1'b1;
        cyc();
        chk("first_dig", 32'(dig_en), 32'h1);
        chk("first_seg", 32'(seg), 32'h3F);

        // Stopped scan pattern over one full period
        rec_dig[0] = dig_en; rec_dp[0] = dp; rec_seg[0] = seg;
        for (int i = 1; i < SCAN_PERIOD; i++) begin
            cyc();
            rec_dig[i] = dig_en; rec_dp[i] = dp; rec_seg[i] = seg;
        end
        for (int i = 0; i < SCAN_PERIOD; i++) begin
            e_dig = ((i % 5) < 4) ? (4'b0001 << (i / 5)) : 4'b0000;
            chk($sformatf("scan[%0d]", i), 32'({rec_dig[i], rec_dp[i], rec_seg[i]}),
                32'({e_dig, ((i / 5) == 2) && ((i % 5) < 4), ((i % 5) < 4) ? 7'h3F : 7'h00}));
        end
        chk("stopped_running", 32'(running), 32'd0);

        // Start and count two seconds
        cmd_start = 1'b1;
        cyc();
        chk("start_running", 32'(running), 32'd1);
        t1 = -1; t2 = -1; nt = 0;
        for (int k = 2; k <= 25; k++) begin
            cyc();
            if (sec_tick) begin
                nt++;
                if (nt == 1) t1 = k;
                else if (nt == 2) t2 = k;
            end
        end
        chk("tick1_cycle", 32'(t1), 32'd11);
        chk("tick2_cycle", 32'(t2), 32'd21);
        chk("tick_count", 32'(nt), 32'd2);
        cmd_stop = 1'b1;
        cyc();
        chk("stop_running", 32'(running), 32'd0);
        wait_dig(4'b0001, "wait_d0");
        chk("sec_units_seg", 32'(seg), 32'h5B);

        // Preset table in STOP
        for (int i = 0; i < 8; i++) begin
            load_value = lv[i].value; load_valid = 1'b1;
            cyc();
            chk($sformatf("load_err[%0d]", i), 32'(load_err), 32'(lv[i].exp_err));
            cap_digits(cap);
            chk($sformatf("load_digits[%0d]", i), 32'(cap), 32'(exp_digits(lv[i].exp_count)));
        end

        // 59:58 -> 59:59 -> 00:00
        cmd_start = 1'b1; cyc();
        wait_tick("wait_tick_a");
        cmd_stop = 1'b1; cyc();
        cap_digits(cap);
        chk("count_5959", 32'(cap), 32'(exp_digits(16'h5959)));
        cmd_start = 1'b1; cyc();
        wait_tick("wait_tick_b");
        cmd_stop = 1'b1; cyc();
        cap_digits(cap);
        chk("count_wrap", 32'(cap), 32'(exp_digits(16'h0000)));

        // Load attempts while running are ignored
        cmd_start = 1'b1; cyc();
        for (int i = 0; i < 3; i++) begin
            load_value = 16'h1111; load_valid = 1'b1;
            cyc();
            chk("run_load_ready", 32'(load_ready), 32'd0);
            chk("run_load_err", 32'(load_err), 32'd0);
        end
        cmd_stop = 1'b1; cyc();
        cap_digits(cap);
        chk("run_load_ignored", 32'(cap), 32'(exp_digits(16'h0000)));

        // Start and stop together
        cmd_start = 1'b1; cmd_stop = 1'b1;
        cyc();
        chk("start_stop_same", 32'(running), 32'd0);

        // Clear on the tick cycle
        load_value = 16'h0123; load_valid = 1'b1; cyc();
        cmd_start = 1'b1; cyc();
        repeat (9) cyc();
        cmd_clear = 1'b1;
        cyc();
        chk("clear_no_tick", 32'(sec_tick), 32'd0);
        chk("clear_keeps_run", 32'(running), 32'd1);
        cmd_stop = 1'b1; cyc();
        cap_digits(cap);
        chk("clear_count", 32'(cap), 32'(exp_digits(16'h0000)));

        // ena dropped mid-SHOW(1) while running
        cmd_start = 1'b1; cyc();
        wait_dig(4'b0010, "wait_d1");
        cyc();
        chk("mid_show1", 32'(dig_en), 32'h2);
        ena = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk($sformatf("ena_off[%0d]", i), 32'({seg, dig_en}), 32'd0);
        end
        ena = 1'b1;
        n = 0; done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            cyc();
            if (dig_en == 4'b0010) n++;
            else done = 1'b1;
        end
        chk("resume_slot", 32'(n), 32'd2);
        repeat (12) cyc();

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({seg, dp, dig_en, running, sec_tick, load_err, load_ready}), 32'h0001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc();
        chk("rerun_first_dig", 32'(dig_en), 32'h1);
        chk("rerun_first_seg", 32'(seg), 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
